// File: rtl/mem_io_responder.sv
// mem_io_responder
//   Memory/IO responder for a byte-wide CPU bus. It has a byte RAM, a UART
//   TX FIFO, a UART RX read path, a free-running cycle counter with a
//   snapshot register, and a halt sequencer that drains the TX FIFO before
//   it reports that the program has stopped.
//
//   Address map (only cpu_a[17:0] is decoded):
//     cpu_a[17:16] != 2'b11  RAM byte, index cpu_a[RAM_AW-1:0]
//     0x30000  rd: RX byte (0x00 if none)  wr: push nonzero byte to TX FIFO
//     0x30004  rd: counter byte 0 + snapshot  wr: request halt
//     0x30005..0x30007  rd: snapshot bytes 1..3
//     other IO addresses  rd: 0x00  wr: ignored
//
// Ports
//   clk_in, rst_in         clock, async active-low reset
//   rdy_in                 bus enable; when low, all state holds
//   cpu_a/cpu_wr/cpu_wdata CPU request, one access per rdy cycle
//   cpu_rdata              read byte, registered, valid one cycle after read
//   io_buffer_full         TX FIFO holds depth-1 or more entries
//   tx_valid/tx_data/tx_ready  TX stream out of the FIFO head
//   rx_valid/rx_data/rx_ready  RX byte in; rx_ready pulses on consume
//   halt_out               sticky, halt sequence complete
//   overflow_err           sticky, a TX push was dropped on a full FIFO
//
// Halt sequencer
//   state      | meaning
//   ST_RUN     | normal operation
//   ST_DRAIN   | halt requested, waiting for the TX FIFO to empty
//   ST_STOPPED | halted; writes ignored, reads still served
module mem_io_responder #(
  parameter int RAM_AW    = 17,
  parameter int TXF_WIDTH = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] cpu_a,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        io_buffer_full,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        halt_out,
  output logic        overflow_err
);

  localparam int RAM_DEPTH = 1 << RAM_AW;
  localparam int TXF_DEPTH = 1 << TXF_WIDTH;
  localparam logic [TXF_WIDTH:0] FIFO_FULL_CNT = {1'b1, {TXF_WIDTH{1'b0}}};
  localparam logic [TXF_WIDTH:0] FIFO_NEAR_CNT = {1'b0, {TXF_WIDTH{1'b1}}};

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_STOPPED
  } halt_state_t;

  halt_state_t state, state_next;

  logic [7:0]           mem [RAM_DEPTH];
  logic [7:0]           txf [TXF_DEPTH];
  logic [TXF_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [TXF_WIDTH:0]   count, count_next;
  logic [31:0]          cycle_cnt;
  logic [23:0]          snap_hi;      // snapshot bytes 1..3; byte 0 is returned live
  logic [7:0]           ram_q, io_q, io_next;
  logic                 rd_from_ram;

  logic              io_sel;
  logic [15:0]       io_off;
  logic [RAM_AW-1:0] ram_idx;
  logic              wr_en, rd_en, ram_we, ram_re;
  logic              push_req, push, pop, halt_req, fifo_full;
  logic              unused_hi;

  assign unused_hi = ^cpu_a[31:18];

  assign io_sel  = (cpu_a[17:16] == 2'b11);
  assign io_off  = cpu_a[15:0];
  assign ram_idx = cpu_a[RAM_AW-1:0];

  // Once stopped, every write (RAM or IO) is dropped; reads keep working.
  assign wr_en  = rdy_in && cpu_wr && (state != ST_STOPPED);
  assign rd_en  = rdy_in && !cpu_wr;
  assign ram_we = wr_en && !io_sel;
  assign ram_re = rd_en && !io_sel;

  assign push_req  = wr_en && io_sel && (io_off == 16'h0000) && (cpu_wdata != 8'h00);
  assign halt_req  = wr_en && io_sel && (io_off == 16'h0004);
  assign fifo_full = (count == FIFO_FULL_CNT);
  assign tx_valid  = (count != '0);
  assign tx_data   = tx_valid ? txf[rd_ptr] : 8'h00;
  assign pop       = rdy_in && tx_valid && tx_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
  assign push      = push_req && (!fifo_full || pop);
  assign count_next = count + {{TXF_WIDTH{1'b0}}, push} - {{TXF_WIDTH{1'b0}}, pop};

  // Gated with rst_in so the pulse is forced low while reset is held.
  assign rx_ready = rst_in && rd_en && io_sel && (io_off == 16'h0000) && rx_valid;

  assign halt_out  = (state == ST_STOPPED);
  assign cpu_rdata = rd_from_ram ? ram_q : io_q;

  always_comb begin
    io_next = 8'h00;
    case (io_off)
      16'h0000: if (rx_valid) io_next = rx_data;
      16'h0004: io_next = cycle_cnt[7:0];
      16'h0005: io_next = snap_hi[7:0];
      16'h0006: io_next = snap_hi[15:8];
      16'h0007: io_next = snap_hi[23:16];
      default:  io_next = 8'h00;
    endcase
  end

  // RAM and FIFO storage are not reset.
  always_ff @(posedge clk_in) begin
    if (ram_we) mem[ram_idx] <= cpu_wdata;
    if (ram_re) ram_q <= mem[ram_idx];
  end

  always_ff @(posedge clk_in) begin
    if (push) txf[wr_ptr] <= cpu_wdata;
  end

  // Reset clears rd_from_ram and io_q, so cpu_rdata reads 0 and any read
  // in flight at reset is discarded.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rd_from_ram    <= 1'b0;
      io_q           <= 8'h00;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      io_buffer_full <= 1'b0;
      overflow_err   <= 1'b0;
      cycle_cnt      <= 32'h0;
      snap_hi        <= 24'h0;
    end else if (rdy_in) begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (rd_en) begin
        rd_from_ram <= !io_sel;
        if (io_sel) io_q <= io_next;
        if (io_sel && (io_off == 16'h0004)) snap_hi <= cycle_cnt[31:8];
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count          <= count_next;
      io_buffer_full <= (count_next >= FIFO_NEAR_CNT);
      if (push_req && !push) overflow_err <= 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= ST_RUN;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:     if (halt_req) state_next = ST_DRAIN;
      ST_DRAIN:   if (rdy_in && (count == '0) && !push) state_next = ST_STOPPED;
      ST_STOPPED: state_next = ST_STOPPED;
      default:    state_next = ST_RUN;
    endcase
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Testbench for mem_io_responder. The stimulus driver runs a
// transaction-level model built from queues and an associative RAM image.
// It pushes the expected per-cycle status, read data and TX bytes into
// queues. Monitors on the falling edge pop those queues and compare them
// with the DUT.
module tb_mem_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b0;
  logic [31:0] cpu_a = 32'h0;
  logic        cpu_wr = 1'b0;
  logic [7:0]  cpu_wdata = 8'h0;
  logic [7:0]  cpu_rdata;
  logic        io_buffer_full;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h0;
  logic        rx_ready;
  logic        halt_out;
  logic        overflow_err;

  mem_io_responder dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .cpu_a(cpu_a), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .io_buffer_full(io_buffer_full), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .halt_out(halt_out), .overflow_err(overflow_err)
  );

  always #5 clk_in = ~clk_in;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { int due; logic [7:0] v; } rd_t;
  typedef struct { int due; bit tv; logic [7:0] td; bit full; bit halt; bit ovf; bit rxr; } st_t;

  // Reference model state: 0 = running, 1 = draining, 2 = stopped
  logic [7:0]  m_mem [int];
  logic [7:0]  m_fifo [$];
  int          m_st = 0;
  bit          m_ovf = 0;
  logic [31:0] m_cnt = 0;
  logic [31:0] m_snap = 0;

  logic [7:0] exp_tx [$];
  rd_t        rd_q [$];
  st_t        st_q [$];

  // One bus cycle: drive the inputs, then advance the model over the next edge.
  task automatic cycle(input bit rdy, input bit wr, input logic [31:0] a, input logic [7:0] d,
                       input bit txr, input bit rxv, input logic [7:0] rxd);
    bit io; int off; int idx; int old_size; bit pop; bit pushed; bit was_drain;
    st_t s; rd_t r;
    @(posedge clk_in); #1;
    rst_in = 1'b1; rdy_in = rdy; cpu_wr = wr; cpu_a = a; cpu_wdata = d;
    tx_ready = txr; rx_valid = rxv; rx_data = rxd;
    io  = (a[17:16] == 2'b11);
    off = int'(a[15:0]);
    idx = int'(a[16:0]);
    s.due  = cyc;
    s.tv   = (m_fifo.size() > 0);
    s.td   = s.tv ? m_fifo[0] : 8'h00;
    s.full = (m_fifo.size() >= 7);
    s.halt = (m_st == 2);
    s.ovf  = m_ovf;
    s.rxr  = rdy && !wr && io && (off == 0) && rxv;
    st_q.push_back(s);
    if (rdy) begin
      old_size  = m_fifo.size();
      was_drain = (m_st == 1);
      pop       = (old_size > 0) && txr;
      pushed    = 0;
      if (pop) void'(m_fifo.pop_front());
      if (wr && m_st != 2) begin
        if (!io) m_mem[idx] = d;
        else if (off == 0 && d != 8'h00) begin
          if (old_size < 8 || pop) begin
            m_fifo.push_back(d); exp_tx.push_back(d); pushed = 1;
          end else m_ovf = 1;
        end else if (off == 4 && m_st == 0) m_st = 1;
      end
      if (was_drain && old_size == 0 && !pushed) m_st = 2;
      if (!wr) begin
        r.due = cyc + 1;
        r.v   = 8'h00;
        if (!io) r.v = m_mem[idx];
        else case (off)
          0: r.v = rxv ? rxd : 8'h00;
          4: begin r.v = m_cnt[7:0]; m_snap = m_cnt; end
          5: r.v = m_snap[15:8];
          6: r.v = m_snap[23:16];
          7: r.v = m_snap[31:24];
          default: r.v = 8'h00;
        endcase
        rd_q.push_back(r);
      end
      m_cnt = m_cnt + 1;
    end
  endtask

  task automatic idle(input int n, input bit txr);
    for (int i = 0; i < n; i++) cycle(1, 0, 32'h0003000C, 8'h00, txr, 0, 8'h00);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cpu_rdata"}, 32'(cpu_rdata), 32'h0);
    chk({tag, "_tx_valid"}, 32'(tx_valid), 32'h0);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'h0);
    chk({tag, "_rx_ready"}, 32'(rx_ready), 32'h0);
    chk({tag, "_io_buffer_full"}, 32'(io_buffer_full), 32'h0);
    chk({tag, "_halt_out"}, 32'(halt_out), 32'h0);
    chk({tag, "_overflow_err"}, 32'(overflow_err), 32'h0);
  endtask

  // Leaves rst_in low; the next cycle() releases it together with its inputs.
  task automatic do_reset();
    @(posedge clk_in); #1;
    rst_in = 1'b0; rdy_in = 1'b1; cpu_wr = 1'b0; cpu_a = 32'h00030000;
    tx_ready = 1'b1; rx_valid = 1'b1;
    #1;
    chk_reset_outputs("reset_async");
    m_fifo.delete(); exp_tx.delete(); rd_q.delete(); st_q.delete();
    m_st = 0; m_ovf = 0; m_cnt = 0; m_snap = 0;
    repeat (2) @(posedge clk_in);
    #1;
    chk_reset_outputs("reset_held");
  endtask

  // Scoreboard monitor
  always @(negedge clk_in) begin : mon
    st_t s; rd_t r;
    if (rst_in) begin
      while (st_q.size() > 0 && st_q[0].due <= cyc) begin
        s = st_q.pop_front();
        chk("status_cycle", 32'(cyc), 32'(s.due));
        chk("tx_valid", 32'(tx_valid), 32'(s.tv));
        if (s.tv) chk("tx_head", 32'(tx_data), 32'(s.td));
        chk("io_buffer_full", 32'(io_buffer_full), 32'(s.full));
        chk("halt_out", 32'(halt_out), 32'(s.halt));
        chk("overflow_err", 32'(overflow_err), 32'(s.ovf));
        chk("rx_ready", 32'(rx_ready), 32'(s.rxr));
      end
      while (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
        r = rd_q.pop_front();
        chk("rd_cycle", 32'(cyc), 32'(r.due));
        chk("cpu_rdata", 32'(cpu_rdata), 32'(r.v));
      end
      if (rdy_in && tx_valid && tx_ready) begin
        if (exp_tx.size() == 0) chk("tx_queue_nonempty", 32'(exp_tx.size() > 0), 32'h1);
        else chk("tx_stream", 32'(tx_data), 32'(exp_tx.pop_front()));
      end
    end
  end

  function automatic logic [31:0] pool_addr(input int k);
    return (32'(k) * 32'h00013579) & 32'h0002FFFF;
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int k; int off; logic [7:0] d; bit drained;
    #1 rst_in = 1'b0;
    #1 chk_reset_outputs("reset_pre_clock");
    do_reset();

    // RAM write then read next cycle, including an aliased address
    cycle(1, 1, 32'h00000010, 8'hA5, 0, 0, 8'h00);
    cycle(1, 0, 32'h00000010, 8'h00, 0, 0, 8'h00);
    cycle(1, 1, 32'h00020011, 8'h3C, 0, 0, 8'h00);
    cycle(1, 0, 32'h00000011, 8'h00, 0, 0, 8'h00);
    idle(2, 0);

    // Zero byte to TX is ignored
    cycle(1, 1, 32'h00030000, 8'h00, 0, 0, 8'h00);
    idle(2, 0);

    // Fill the FIFO, overflow it, push while full with a pop, then drain
    for (int i = 0; i < 8; i++) cycle(1, 1, 32'h00030000, 8'h61 + 8'(i), 0, 0, 8'h00);
    idle(1, 0);
    cycle(1, 1, 32'h00030000, 8'h69, 0, 0, 8'h00);
    idle(1, 0);
    cycle(1, 1, 32'h00030000, 8'h6A, 1, 0, 8'h00);
    idle(12, 1);

    // RX reads with and without a byte offered
    cycle(1, 0, 32'h00030000, 8'h00, 0, 1, 8'h5A);
    cycle(1, 0, 32'h00030000, 8'h00, 0, 0, 8'h77);
    cycle(1, 0, 32'hFFFF0000, 8'h00, 0, 1, 8'hC3);

    // Counter snapshot: bytes 1..3 come from the snapshot while time moves on
    cycle(1, 0, 32'h00030004, 8'h00, 0, 0, 8'h00);
    idle(3, 0);
    cycle(1, 0, 32'h00030005, 8'h00, 0, 0, 8'h00);
    idle(300, 0);
    cycle(1, 0, 32'h00030006, 8'h00, 0, 0, 8'h00);
    cycle(1, 0, 32'h00030007, 8'h00, 0, 0, 8'h00);
    cycle(1, 0, 32'h00030004, 8'h00, 0, 0, 8'h00);
    cycle(1, 0, 32'h00030005, 8'h00, 0, 0, 8'h00);
    cycle(1, 1, 32'h00030008, 8'h55, 0, 0, 8'h00);
    cycle(1, 0, 32'h00030008, 8'h00, 0, 0, 8'h00);

    // Mid-operation reset with bytes queued and overflow set
    for (int i = 0; i < 9; i++) cycle(1, 1, 32'h00030000, 8'h30 + 8'(i), 0, 0, 8'h00);
    cycle(1, 0, 32'h00000010, 8'h00, 0, 0, 8'h00);
    do_reset();

    // Halt with 3 bytes queued, stall with rdy_in low mid-drain, then complete
    for (int i = 0; i < 3; i++) cycle(1, 1, 32'h00030000, 8'h41 + 8'(i), 0, 0, 8'h00);
    cycle(1, 1, 32'h00030004, 8'h99, 0, 0, 8'h00);
    idle(3, 0);
    cycle(1, 0, 32'h00030000, 8'h00, 1, 0, 8'h00);
    for (int i = 0; i < 5; i++) cycle(0, 0, 32'h00030000, 8'h00, 1, 1, 8'h11);
    cycle(1, 0, 32'h00030004, 8'h00, 1, 0, 8'h00);
    idle(6, 1);
    cycle(1, 1, 32'h00000010, 8'hFF, 1, 0, 8'h00);
    cycle(1, 1, 32'h00030000, 8'h7A, 1, 0, 8'h00);
    cycle(1, 0, 32'h00000010, 8'h00, 1, 0, 8'h00);
    cycle(1, 0, 32'h00030000, 8'h00, 1, 1, 8'hE7);
    idle(2, 1);
    do_reset();

    // Random phase
    for (int i = 0; i < 16; i++) cycle(1, 1, pool_addr(i), 8'($urandom), 0, 0, 8'h00);
    for (int n = 0; n < 3000; n++) begin
      if (n % 400 == 399) do_reset();
      k = int'($urandom_range(0, 15));
      d = 8'($urandom);
      if ($urandom_range(0, 7) == 0) d = 8'h00;
      case (k)
        0, 1, 2, 3, 4: cycle($urandom_range(0, 7) != 0, 0, pool_addr(int'($urandom_range(0, 15))), 8'h00,
                             $urandom_range(0, 2) != 0, 1'($urandom), 8'($urandom));
        5, 6, 7: cycle($urandom_range(0, 7) != 0, 1, pool_addr(int'($urandom_range(0, 15))), d,
                       $urandom_range(0, 2) != 0, 1'($urandom), 8'($urandom));
        8, 9, 10: cycle($urandom_range(0, 7) != 0, 1, 32'h00030000, d,
                        $urandom_range(0, 2) != 0, 1'($urandom), 8'($urandom));
        11: cycle($urandom_range(0, 7) != 0, 0, 32'h00030000, 8'h00,
                  $urandom_range(0, 2) != 0, 1'($urandom), 8'($urandom));
        12: begin
          off = int'($urandom_range(4, 7));
          cycle($urandom_range(0, 7) != 0, 0, 32'h00030000 + 32'(off), 8'h00,
                $urandom_range(0, 2) != 0, 1'($urandom), 8'($urandom));
        end
        13: cycle($urandom_range(0, 7) != 0, 1'($urandom), 32'h00030008 + 32'($urandom_range(0, 15)), d,
                  $urandom_range(0, 2) != 0, 1'($urandom), 8'($urandom));
        14: if ($urandom_range(0, 19) == 0)
              cycle(1, 1, 32'h00030004, d, $urandom_range(0, 2) != 0, 0, 8'h00);
            else
              cycle(1, 0, pool_addr(int'($urandom_range(0, 15))), 8'h00, 1, 0, 8'h00);
        default: idle(1, $urandom_range(0, 2) != 0);
      endcase
    end

    // Drain whatever is left, bounded
    drained = 0;
    for (int i = 0; i < 50 && !drained; i++) begin
      idle(1, 1);
      if (m_fifo.size() == 0) drained = 1;
    end
    idle(3, 1);
    chk("final_model_drained", 32'(drained), 32'h1);
    chk("final_tx_all_seen", 32'(exp_tx.size()), 32'h0);
    chk("final_tx_valid", 32'(tx_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
